// File: rtl/priority_arbiter_rr_pkg.sv
// Shared types and constants for the fixed / round-robin priority arbiter.
// FSM state encoding and the values carried on the mode input.
package priority_arbiter_rr_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_arbiter_rr_pri_enc.sv
// Combinational priority encoder: reports the index of the highest set request bit.
// found is low, and idx is zero, when no bit is set.
module pri_enc_n
    import priority_arbiter_rr_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         found
);

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter_rr.sv
// N-way arbiter with selectable fixed (highest index wins) or round-robin priority.
// Two-state FSM; every output is registered and a grant is held until ack or abandon.
module priority_arbiter_rr
    import priority_arbiter_rr_pkg::*;
#(
    parameter int unsigned N          = 8,
    parameter int unsigned W          = $clog2(N),
    parameter bit          RR_DEFAULT = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         ack,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         v
);

    localparam logic [W-1:0] LastIdx = W'(N - 1);

    arb_state_e   state_q, state_d;
    logic [N-1:0] gnt_q, gnt_d;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic         v_q, v_d;
    logic         mode_q, mode_d;

    logic [N-1:0] hi_mask;
    logic [N-1:0] req_hi;
    logic [N-1:0] req_hi_rev;
    logic [N-1:0] req_rev;
    logic [W-1:0] fix_idx;
    logic [W-1:0] hi_idx_rev;
    logic [W-1:0] all_idx_rev;
    logic         fix_found;
    logic         hi_found;
    logic         all_found;
    logic [W-1:0] rr_idx;
    logic [W-1:0] win_idx;
    logic [W-1:0] next_ptr;
    logic         mode_eff;

    // Bit-reversal turns the highest-wins encoder into a lowest-wins search.
    always_comb begin
        hi_mask    = '0;
        req_hi_rev = '0;
        req_rev    = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (W'(i) >= ptr_q);
        end
        req_hi = req & hi_mask;
        for (int i = 0; i < N; i++) begin
            req_hi_rev[i] = req_hi[N-1-i];
            req_rev[i]    = req[N-1-i];
        end
    end

    pri_enc_n #(.N(N)) u_enc_fixed (
        .req   (req),
        .idx   (fix_idx),
        .found (fix_found)
    );

    pri_enc_n #(.N(N)) u_enc_rr_hi (
        .req   (req_hi_rev),
        .idx   (hi_idx_rev),
        .found (hi_found)
    );

    pri_enc_n #(.N(N)) u_enc_rr_wrap (
        .req   (req_rev),
        .idx   (all_idx_rev),
        .found (all_found)
    );

    // Decisions happen only in IDLE, where the live mode input is what counts.
    assign mode_eff = (state_q == StIdle) ? mode : mode_q;

    always_comb begin
        rr_idx = '0;
        if (hi_found) begin
            rr_idx = LastIdx - hi_idx_rev;
        end else if (all_found) begin
            rr_idx = LastIdx - all_idx_rev;
        end
        win_idx  = (mode_eff == MODE_RR) ? rr_idx : fix_idx;
        next_ptr = (win_idx == LastIdx) ? '0 : win_idx + W'(1);
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        v_d     = v_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle: begin
                mode_d = mode;
                if (fix_found) begin
                    state_d = StGrant;
                    gnt_d   = N'(1) << win_idx;
                    idx_d   = win_idx;
                    v_d     = 1'b1;
                    ptr_d   = next_ptr;
                end else begin
                    gnt_d = '0;
                    idx_d = '0;
                    v_d   = 1'b0;
                end
            end
            StGrant: begin
                // Release on ack or when the holder withdraws its request.
                if (ack || !req[idx_q]) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    idx_d   = '0;
                    v_d     = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
                idx_d   = '0;
                v_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            v_q     <= 1'b0;
            mode_q  <= RR_DEFAULT;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            v_q     <= v_d;
            mode_q  <= mode_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign v       = v_q;

endmodule

// File: tb/tb_priority_arbiter_rr.sv
// Self-checking bench for priority_arbiter_rr (N=4): directed scenarios plus random
// traffic compared against a cycle-level behavioural model of the arbitration rules.
module tb_priority_arbiter_rr;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    logic [N-1:0] gnt;
    logic [W-1:0] gnt_idx;
    logic         v;

    int total = 0;
    int bad   = 0;

    // Model: busy flag, granted index, round-robin start pointer.
    int m_v;
    int m_idx;
    int m_ptr;

    always #5 clk = ~clk;

    priority_arbiter_rr #(
        .N          (N),
        .RR_DEFAULT (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .mode    (mode),
        .ack     (ack),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .v       (v)
    );

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] g;
        g = '0;
        if (m_v != 0) g[m_idx] = 1'b1;
        return g;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_v = 0; m_idx = 0; m_ptr = 0;
        end else if (m_v == 0) begin
            if (req != '0) begin
                w = -1;
                if (mode == 1'b0) begin
                    for (int i = N - 1; i >= 0; i--) if (w < 0 && req[i]) w = i;
                end else begin
                    for (int k = 0; k < N; k++) if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                end
                m_v = 1; m_idx = w; m_ptr = (w + 1) % N;
            end
        end else if (ack || !req[m_idx]) begin
            m_v = 0; m_idx = 0;
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs read #1 later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; ack = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; ack = 1'b0; mode = 1'b0;
        cycle();
        cycle();
        total++; if (v !== 1'b0) begin bad++; $display("FAIL reset_v got=%b want=0", v); end
        total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", gnt_idx); end
        rst = 1'b0; req = '0;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; req = 4'b0110;
        cycle();
        total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL fixed_gnt got=%b want=0100", gnt); end
        total++; if (gnt_idx !== 2'd2) begin bad++; $display("FAIL fixed_idx got=%0d want=2", gnt_idx); end
        total++; if (v !== 1'b1) begin bad++; $display("FAIL fixed_v got=%b want=1", v); end
        ack = 1'b1;
        cycle();
        total++; if (v !== 1'b0) begin bad++; $display("FAIL fixed_release got=%b want=0", v); end
        ack = 1'b0; req = '0;
        cycle();
    endtask

    task automatic test_rr_sequence();
        int seq[5] = '{0, 1, 2, 3, 0};
        do_reset();
        mode = 1'b1; req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cycle();
            total++;
            if (v !== 1'b1 || gnt_idx !== W'(seq[g])) begin
                bad++; $display("FAIL rr_seq[%0d] got v=%b idx=%0d want v=1 idx=%0d", g, v, gnt_idx, seq[g]);
            end
            ack = 1'b1;
            cycle();
            total++; if (v !== 1'b0) begin bad++; $display("FAIL rr_gap[%0d] got v=%b want=0", g, v); end
            ack = 1'b0;
        end
        req = '0;
        cycle();
    endtask

    task automatic test_wrap();
        do_reset();
        mode = 1'b1; req = 4'b1000;
        cycle();
        total++; if (gnt_idx !== 2'd3) begin bad++; $display("FAIL wrap_setup got=%0d want=3", gnt_idx); end
        ack = 1'b1; cycle(); ack = 1'b0;
        req = 4'b0001;
        cycle();
        total++; if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin bad++; $display("FAIL wrap_idx got=%0d gnt=%b want=0", gnt_idx, gnt); end
        ack = 1'b1; cycle(); ack = 1'b0;
        req = 4'b1111;
        cycle();
        total++; if (gnt_idx !== 2'd1) begin bad++; $display("FAIL wrap_ptr got=%0d want=1", gnt_idx); end
        ack = 1'b1; cycle(); ack = 1'b0; req = '0;
    endtask

    task automatic test_hold_and_abandon();
        do_reset();
        mode = 1'b1; req = 4'b0010;
        cycle();
        req = 4'b1110;
        cycle();
        total++; if (gnt !== 4'b0010 || v !== 1'b1) begin bad++; $display("FAIL hold got=%b want=0010", gnt); end
        req = 4'b1100; ack = 1'b0;
        cycle();
        total++; if (v !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL abandon got v=%b gnt=%b want 0", v, gnt); end
        req = '0;
        cycle();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        mode = 1'b1; req = 4'b1111;
        cycle();
        ack = 1'b1; cycle(); ack = 1'b0;
        cycle();
        total++; if (gnt_idx !== 2'd1) begin bad++; $display("FAIL midrst_setup got=%0d want=1", gnt_idx); end
        rst = 1'b1;
        cycle();
        total++; if (v !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL midrst_clear got v=%b gnt=%b want 0", v, gnt); end
        rst = 1'b0;
        cycle();
        total++; if (gnt_idx !== 2'd0 || v !== 1'b1) begin bad++; $display("FAIL midrst_ptr got=%0d want=0", gnt_idx); end
        ack = 1'b1; cycle(); ack = 1'b0; req = '0;
    endtask

    task automatic test_idle_ack();
        do_reset();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            ack = c[0];
            cycle();
            total++; if (v !== 1'b0 || gnt !== 4'b0000) begin bad++; $display("FAIL idle_ack[%0d] got v=%b gnt=%b want 0", c, v, gnt); end
        end
        ack = 1'b0;
    endtask

    task automatic test_mode_change();
        do_reset();
        mode = 1'b0; req = 4'b1111;
        cycle();
        mode = 1'b1;
        cycle();
        total++; if (gnt_idx !== 2'd3) begin bad++; $display("FAIL mode_hold got=%0d want=3", gnt_idx); end
        ack = 1'b1; cycle(); ack = 1'b0;
        cycle();
        total++; if (gnt_idx !== 2'd0) begin bad++; $display("FAIL mode_switch got=%0d want=0", gnt_idx); end
        ack = 1'b1; cycle(); ack = 1'b0; req = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            req = N'($urandom_range(0, 15));
            ack = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            cycle();
            total++;
            if (v !== (m_v != 0) || gnt_idx !== W'(m_idx) || gnt !== exp_gnt()) begin
                bad++;
                $display("FAIL random[%0d] got v=%b idx=%0d gnt=%b want v=%0d idx=%0d gnt=%b",
                         c, v, gnt_idx, gnt, m_v, m_idx, exp_gnt());
            end
        end
        rst = 1'b0; req = '0; ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; mode = 1'b0; ack = 1'b0;
        m_v = 0; m_idx = 0; m_ptr = 0;
        #2;
        test_reset();
        test_fixed();
        test_rr_sequence();
        test_wrap();
        test_hold_and_abandon();
        test_reset_mid_grant();
        test_idle_ack();
        test_mode_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
